// File: rtl/iter_divider.sv
// -----------------------------------------------------------------------------
// iter_divider
//   Iterative signed divider. It uses one restoring-division step per clock on
//   the operand magnitudes, then applies a one-cycle sign/flag fix-up.
//   Results truncate toward zero, and the remainder takes the dividend's sign.
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   start        begin a division (looked at only when busy=0)
//   dividend     signed numerator, captured on an accepted start
//   divisor      signed denominator, captured on an accepted start
//   busy         high while CALC/FIX are running
//   done         one-cycle pulse when results are valid
//   quotient     signed quotient (held until the next done)
//   remainder    signed remainder (held until the next done)
//   div_by_zero  divisor was zero: quotient=-1, remainder=dividend
//   overflow     most-negative / -1: quotient wraps to most-negative, remainder=0
// -----------------------------------------------------------------------------
module iter_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    LAST     = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH:0]   MAG_ONE  = {{WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] q_work;
  logic [WIDTH:0]   r_work;
  logic [WIDTH:0]   d_mag;
  logic [WIDTH-1:0] a_orig;
  logic             a_neg;
  logic             b_neg;

  logic [WIDTH:0]   dvd_ext;
  logic [WIDTH:0]   dvs_ext;
  logic [WIDTH:0]   dvd_mag;
  logic [WIDTH:0]   dvs_mag;
  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   r_diff;
  logic             r_ge;
  logic [WIDTH-1:0] r_mag;
  logic             unused_bits;

  // Operand magnitudes are formed one bit wider than the operands. This lets
  // the most-negative value negate to its true positive magnitude instead of
  // wrapping back to itself.
  always_comb begin
    dvd_ext = {dividend[WIDTH-1], dividend};
    dvs_ext = {divisor[WIDTH-1], divisor};
    dvd_mag = dvd_ext[WIDTH] ? -dvd_ext : dvd_ext;
    dvs_mag = dvs_ext[WIDTH] ? -dvs_ext : dvs_ext;
  end

  // This is one restoring step. The next dividend bit (MSB first out of
  // q_work) is shifted into the partial remainder, and a trial subtraction is
  // tried. The subtraction is kept only when it does not go negative.
  always_comb begin
    r_shift = {r_work[WIDTH-1:0], q_work[WIDTH-1]};
    r_diff  = r_shift - d_mag;
    r_ge    = (r_shift >= d_mag);
    r_mag   = r_work[WIDTH-1:0];
  end

  // The top magnitude bits are always zero once a value has been negated:
  // |dividend| <= 2^(WIDTH-1) and the remainder is always below |divisor|.
  // These bits are folded here so that dropping them is deliberate.
  assign unused_bits = ^{dvd_mag[WIDTH], r_work[WIDTH]};

  // This is the main control FSM. It has registered outputs.
  // IDLE/DONE accept a start and capture operands. CALC shifts out WIDTH
  // quotient bits. FIX applies signs and special cases, and writes the result
  // registers on the way into DONE. DONE is therefore the only cycle with
  // done=1. A start seen in DONE goes straight back to CALC, which allows
  // back-to-back operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      q_work      <= '0;
      r_work      <= '0;
      d_mag       <= '0;
      a_orig      <= '0;
      a_neg       <= 1'b0;
      b_neg       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            q_work <= dvd_mag[WIDTH-1:0];
            r_work <= '0;
            d_mag  <= dvs_mag;
            a_orig <= dividend;
            a_neg  <= dividend[WIDTH-1];
            b_neg  <= divisor[WIDTH-1];
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= CALC;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          r_work <= r_ge ? r_diff : r_shift;
          q_work <= {q_work[WIDTH-2:0], r_ge};
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            state <= FIX;
          end
        end
        FIX: begin
          if (d_mag == '0) begin
            quotient    <= '1;
            remainder   <= a_orig;
            div_by_zero <= 1'b1;
            overflow    <= 1'b0;
          end else if (a_orig == MOST_NEG && b_neg && d_mag == MAG_ONE) begin
            quotient    <= MOST_NEG;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b1;
          end else begin
            // Negating a zero magnitude stays zero, so the quotient only
            // becomes negative when it is non-zero.
            quotient    <= (a_neg ^ b_neg) ? -q_work : q_work;
            remainder   <= a_neg ? -r_mag : r_mag;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
